// File: rtl/bus_cmd_pkg.sv
`default_nettype none
//==============================================================================
// Module   : bus_cmd_pkg
// Summary  : Shared states, command-byte field positions and IRQ token.
// Revision : 1.0 - initial release
//==============================================================================
package bus_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_CS   = 3'd2,
        ST_RD_CS   = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_SEND = 3'd5
    } state_e;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_LEN_MSB  = 6;
    localparam int CMD_LEN_LSB  = 4;
    localparam int CMD_ADDR_MSB = 3;

    localparam logic [7:0] IRQ_TOKEN = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/bus_cmd_initiator.sv
`default_nettype none
//==============================================================================
// Module   : bus_cmd_initiator
// Summary  : Host byte commands -> single/burst peripheral bus reads/writes.
//            Define BUS_CMD_IRQ_REPORT_EN to report irq rising edges as 0xA5.
// Revision : 1.0 - initial release
//==============================================================================
module bus_cmd_initiator
    import bus_cmd_pkg::*;
#(
    parameter int RD_WAIT   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] bus_ad,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       bus_rw,
    output logic       bus_cs,
    input  logic       irq,
    output logic       busy
);

    localparam int CNT_W  = $clog2(MAX_BURST);
    localparam int WAIT_W = (RD_WAIT < 2) ? 1 : $clog2(RD_WAIT + 1);

    state_e              r_state_q, w_state_d;
    logic [CNT_W-1:0]    r_cnt_q, w_cnt_d;
    logic [3:0]          r_addr_q, w_addr_d;
    logic [WAIT_W-1:0]   r_wait_q, w_wait_d;
    logic [7:0]          r_rsp_data_q, w_rsp_data_d;
    logic [3:0]          r_bus_ad_q, w_bus_ad_d;
    logic                r_bus_rw_q, w_bus_rw_d;
    logic [7:0]          r_bus_wdata_q, w_bus_wdata_d;
    logic                w_tok, w_tok_d;
    logic                w_irq_pend, w_irq_clr;

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_addr_d      = r_addr_q;
        w_wait_d      = r_wait_q;
        w_rsp_data_d  = r_rsp_data_q;
        w_bus_wdata_d = r_bus_wdata_q;
        w_tok_d       = w_tok;
        w_irq_clr     = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_cnt_d   = CNT_W'(cmd_data[CMD_LEN_MSB:CMD_LEN_LSB]);
                    w_addr_d  = cmd_data[CMD_ADDR_MSB:0];
                    w_state_d = cmd_data[CMD_RW_BIT] ? ST_RD_CS : ST_WR_DATA;
                end else if (w_irq_pend) begin
                    w_rsp_data_d = IRQ_TOKEN;
                    w_tok_d      = 1'b1;
                    w_state_d    = ST_RD_SEND;
                end
            end
            ST_WR_DATA: begin
                if (cmd_valid) begin
                    w_bus_wdata_d = cmd_data;
                    w_state_d     = ST_WR_CS;
                end
            end
            ST_WR_CS: begin
                w_addr_d  = r_addr_q + 4'd1;
                w_cnt_d   = r_cnt_q - CNT_W'(1);
                w_state_d = (r_cnt_q == '0) ? ST_IDLE : ST_WR_DATA;
            end
            ST_RD_CS: begin
                w_wait_d  = WAIT_W'(RD_WAIT);
                w_state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (r_wait_q == '0) begin
                    w_rsp_data_d = bus_rdata;
                    w_state_d    = ST_RD_SEND;
                end else begin
                    w_wait_d = r_wait_q - WAIT_W'(1);
                end
            end
            ST_RD_SEND: begin
                if (rsp_ready) begin
                    if (w_tok) begin
                        w_tok_d   = 1'b0;
                        w_irq_clr = 1'b1;
                        w_state_d = ST_IDLE;
                    end else begin
                        w_addr_d  = r_addr_q + 4'd1;
                        w_cnt_d   = r_cnt_q - CNT_W'(1);
                        w_state_d = (r_cnt_q == '0) ? ST_IDLE : ST_RD_CS;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Bus address/direction change only when a strobe starts, so they hold otherwise.
    always_comb begin
        w_bus_ad_d = r_bus_ad_q;
        w_bus_rw_d = r_bus_rw_q;
        if (w_state_d == ST_WR_CS || w_state_d == ST_RD_CS) begin
            w_bus_ad_d = w_addr_d;
            w_bus_rw_d = (w_state_d == ST_RD_CS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_cnt_q       <= '0;
            r_addr_q      <= '0;
            r_wait_q      <= '0;
            r_rsp_data_q  <= '0;
            r_bus_ad_q    <= '0;
            r_bus_rw_q    <= 1'b1;
            r_bus_wdata_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_addr_q      <= w_addr_d;
            r_wait_q      <= w_wait_d;
            r_rsp_data_q  <= w_rsp_data_d;
            r_bus_ad_q    <= w_bus_ad_d;
            r_bus_rw_q    <= w_bus_rw_d;
            r_bus_wdata_q <= w_bus_wdata_d;
        end
    end

`ifdef BUS_CMD_IRQ_REPORT_EN
    logic r_irq_q, r_irq_prev_q, r_irq_pend_q, r_tok_q;

    // A new edge wins over a same-cycle clear so no interrupt is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_q      <= 1'b0;
            r_irq_prev_q <= 1'b0;
            r_irq_pend_q <= 1'b0;
            r_tok_q      <= 1'b0;
        end else begin
            r_irq_q      <= irq;
            r_irq_prev_q <= r_irq_q;
            r_tok_q      <= w_tok_d;
            if (r_irq_q && !r_irq_prev_q) begin
                r_irq_pend_q <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq_pend_q <= 1'b0;
            end
        end
    end

    assign w_tok      = r_tok_q;
    assign w_irq_pend = r_irq_pend_q;
`else
    logic w_unused;

    assign w_tok      = 1'b0;
    assign w_irq_pend = 1'b0;
    assign w_unused   = ^{irq, w_tok_d, w_irq_clr};
`endif

    assign cmd_ready = (r_state_q == ST_IDLE) || (r_state_q == ST_WR_DATA);
    assign rsp_valid = (r_state_q == ST_RD_SEND);
    assign rsp_data  = r_rsp_data_q;
    assign bus_cs    = (r_state_q == ST_WR_CS) || (r_state_q == ST_RD_CS);
    assign bus_ad    = r_bus_ad_q;
    assign bus_rw    = r_bus_rw_q;
    assign bus_wdata = r_bus_wdata_q;
    assign busy      = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/bus_cmd_initiator.md
Name: bus_cmd_initiator

Overview:
- Initiator for the on-board 4-bit-address peripheral bus (AD/DI/DO/rw/cs).
- Turns a byte command stream into single or burst register reads/writes and returns read bytes on a byte output stream.
- Sits between a host-side byte link (UART/debug) and peripheral responders; lets a host poke LEDs, timer and switches without the CPU.

Parameters:
- RD_WAIT, 1, clk cycles between the cs read cycle and sampling bus_rdata (min 1).
- MAX_BURST, 8, maximum burst length (fixed by 3-bit length field).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_data  in  8  host byte in
- cmd_valid  in  1  host byte valid
- cmd_ready  out  1  block accepts cmd_data this cycle
- rsp_data  out  8  read byte to host
- rsp_valid  out  1  rsp_data valid
- rsp_ready  in  1  host accepts rsp_data
- bus_ad  out  4  peripheral register address
- bus_wdata  out  8  write data (to responder DI)
- bus_rdata  in  8  read data (from responder DO)
- bus_rw  out  1  1=read, 0=write
- bus_cs  out  1  chip select, one-cycle strobe
- irq  in  1  responder interrupt line (used only with the optional feature)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Command byte: bit7 = rw (1 read), bits6:4 = len-1 (1..8 transfers), bits3:0 = start address.
- Address increments per transfer, wraps mod 16 (0xF -> 0x0).
- Reset: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, bus_cs=0, bus_rw=1, bus_ad=0, bus_wdata=0, busy=0.
- Any handshake: transfer when valid && ready on a rising clk edge.
- States:
  - IDLE: cmd_ready=1. On accept, latch rw/len/addr. Read -> RD_CS. Write -> WR_DATA.
  - WR_DATA: cmd_ready=1. On accept, latch bus_wdata -> WR_CS.
  - WR_CS: exactly one cycle with bus_cs=1, bus_rw=0, bus_ad/bus_wdata stable. Responder captures on negedge within that cycle. Decrement count, increment addr. Count exhausted -> IDLE; else -> WR_DATA.
  - RD_CS: exactly one cycle with bus_cs=1, bus_rw=1. Responder updates DO on that posedge -> RD_WAIT.
  - RD_WAIT: bus_cs=0, wait RD_WAIT cycles, then latch bus_rdata into rsp_data, assert rsp_valid -> RD_SEND.
  - RD_SEND: hold rsp_data/rsp_valid stable until rsp_ready. On accept, decrement/increment. Count exhausted -> IDLE; else -> RD_CS.
- cmd_ready=0 in WR_CS, RD_CS, RD_WAIT and RD_SEND. Host bytes stall, none are dropped.
- bus_cs is never high in two consecutive cycles. bus_cs is low in every non-CS state.
- bus_ad, bus_rw and bus_wdata hold their last values when bus_cs=0.
- Latency:
  - Write: data byte accept -> cs 1 cycle later.
  - Read: command accept -> cs next cycle -> rsp_valid at 2+RD_WAIT cycles after accept.
- Back-to-back: rsp accept and next RD_CS follow in consecutive cycles; no idle gap is required.
- Reset mid-operation: burst is aborted, partial data discarded, pending rsp_valid dropped, return to reset values next cycle.
- A read of an address with side effects (e.g. 0x8 clears IRQ) is issued exactly once per transfer, including while rsp_ready is held low.

Optional Feature:
- Macro: BUS_CMD_IRQ_REPORT_EN.
- Defined:
  - A rising edge of irq (registered, compared with previous value) sets irq_pending.
  - In IDLE with irq_pending and no command accepted that cycle, emit rsp_data=0xA5 via RD_SEND-style handshake, then clear irq_pending.
  - A command and irq_pending in the same IDLE cycle: the command wins, irq_pending is kept.
  - Reset clears irq_pending.
- Undefined: irq is ignored and no 0xA5 bytes are ever produced.

Decomposition:
- Shared package bus_cmd_pkg:
  - State enum (IDLE, WR_DATA, WR_CS, RD_CS, RD_WAIT, RD_SEND).
  - Command field positions (CMD_RW_BIT=7, CMD_LEN_MSB=6, CMD_LEN_LSB=4, CMD_ADDR_MSB=3).
  - IRQ_TOKEN=8'hA5.
- Single module; no sub-module warranted. The bench pairs it with the existing on-board peripheral responder.

Test Plan:
- Write single: cmd 0x00, data 0x5A -> one cs cycle with rw=0, ad=0, wdata=0x5A; the LED register then reads back 0x5A.
- Write burst wrap: cmd 0x1F, data 0x11, 0x22 -> cs at ad=0xF then ad=0x0, data in order, exactly 2 cs pulses.
- Read burst with backpressure: cmd 0xB1 (read, len 4, addr 1), rsp_ready low 5 cycles on the 2nd byte -> 4 bytes from ad 1,2,3,4, exactly 4 read cs pulses, rsp_data stable while stalled.
- Timer IRQ clear: program prescaler 0x000003, mode 0xC1, wait for irq, cmd 0x88 -> rsp bit7=1, irq drops; with BUS_CMD_IRQ_REPORT_EN, 0xA5 is emitted before the read response.
- Reset mid-burst: cmd 0xF0, assert rst after 2nd rsp -> rsp_valid=0, cs=0, cmd_ready=1 next cycle; a new cmd 0x84 then works normally.
- Stall: cmd_valid held with cmd 0x80 while in RD_SEND -> cmd_ready=0, byte accepted only after return to IDLE.
